// File: rtl/uno_deal_ctrl.sv
// uno_deal_ctrl: deck pointer sequencer for the shuffled card store.
// Starts a shuffle, deals the opening hands round-robin, then serves
// player draw requests through a round-robin arbiter, one card per cycle.
// Optional build macro UNO_DEAL_RESHUFFLE_EN: when the deck runs out,
// reshuffle and keep serving draws instead of stopping in EMPTY.
module uno_deal_ctrl #(
   parameter int N_PLAYERS = 4,
   parameter int HAND_SIZE = 7,
   parameter int DECK_SIZE = 108,
   localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_new_game,
   output logic                 o_shuf_start,
   input  logic                 i_shuf_done,
   output logic [6:0]           o_deck_addr,
   input  logic [5:0]           i_deck_card,
   input  logic [N_PLAYERS-1:0] i_req,
   output logic [N_PLAYERS-1:0] o_gnt,
   output logic                 o_card_valid,
   output logic [5:0]           o_card,
   output logic [PW-1:0]        o_player,
   output logic [6:0]           o_remaining,
   output logic                 o_busy,
   output logic                 o_empty
);

   localparam logic [6:0]    DECK      = 7'(DECK_SIZE);
   localparam logic [6:0]    DEAL_LAST = 7'(HAND_SIZE * N_PLAYERS - 1);
   localparam logic [PW-1:0] LAST_PLR  = PW'(N_PLAYERS - 1);

   typedef enum logic [2:0] {
      IDLE, SHUF_REQ, SHUF_WAIT, DEAL, SERVE, EMPTY
   } state_t;

   state_t              state_q, state_d;
   logic [6:0]          ptr_q, ptr_d;     // next deck index to issue
   logic [PW-1:0]       plr_q, plr_d;     // deal destination player
   logic [PW-1:0]       prio_q, prio_d;   // highest-priority requester
`ifdef UNO_DEAL_RESHUFFLE_EN
   logic                reshuf_q, reshuf_d; // shuffle was a mid-game refill
`endif

   logic                arb_hit;
   logic [PW-1:0]       arb_idx;
   logic [N_PLAYERS-1:0] gnt;
   logic                card_valid;
   logic [PW-1:0]       player;
   logic                shuf_start;

   // Round-robin pick: scan from prio_q upward; the lowest offset wins.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int i = N_PLAYERS - 1; i >= 0; i--) begin
         int p;
         p = (int'(prio_q) + i) % N_PLAYERS;
         if (i_req[p]) begin
            arb_hit = 1'b1;
            arb_idx = PW'(p);
         end
      end
   end

   // Next-state, pointer/priority update and per-cycle issue outputs.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      plr_d      = plr_q;
      prio_d     = prio_q;
`ifdef UNO_DEAL_RESHUFFLE_EN
      reshuf_d   = reshuf_q;
`endif
      gnt        = '0;
      card_valid = 1'b0;
      player     = '0;
      shuf_start = 1'b0;
      case (state_q)
         SHUF_REQ: begin
            shuf_start = 1'b1;
            ptr_d      = '0;
            state_d    = SHUF_WAIT;
         end
         SHUF_WAIT: begin
            if (i_shuf_done) begin
               plr_d   = '0;
               state_d = DEAL;
`ifdef UNO_DEAL_RESHUFFLE_EN
               if (reshuf_q) state_d = SERVE;
               reshuf_d = 1'b0;
`endif
            end
         end
         DEAL: begin
            card_valid = 1'b1;
            player     = plr_q;
            ptr_d      = ptr_q + 7'd1;
            plr_d      = (plr_q == LAST_PLR) ? '0 : plr_q + PW'(1);
            if (ptr_q == DEAL_LAST) begin
               prio_d  = '0;
               state_d = SERVE;
            end
         end
         SERVE: begin
            // A same-cycle restart wins over any pending request.
            if (arb_hit && !i_new_game) begin
               gnt[arb_idx] = 1'b1;
               card_valid   = 1'b1;
               player       = arb_idx;
               ptr_d        = ptr_q + 7'd1;
               prio_d       = (arb_idx == LAST_PLR) ? '0 : arb_idx + PW'(1);
               if (ptr_q == DECK - 7'd1) begin
`ifdef UNO_DEAL_RESHUFFLE_EN
                  ptr_d    = '0;
                  reshuf_d = 1'b1;
                  state_d  = SHUF_REQ;
`else
                  state_d  = EMPTY;
`endif
               end
            end
         end
         default: ;
      endcase
      if (i_new_game) begin
         state_d = SHUF_REQ;
         ptr_d   = '0;
`ifdef UNO_DEAL_RESHUFFLE_EN
         reshuf_d = 1'b0;
`endif
      end
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         plr_q    <= '0;
         prio_q   <= '0;
`ifdef UNO_DEAL_RESHUFFLE_EN
         reshuf_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         plr_q    <= plr_d;
         prio_q   <= prio_d;
`ifdef UNO_DEAL_RESHUFFLE_EN
         reshuf_q <= reshuf_d;
`endif
      end
   end

   assign o_shuf_start = shuf_start;
   assign o_deck_addr  = ptr_q;
   assign o_gnt        = gnt;
   assign o_card_valid = card_valid;
   assign o_card       = card_valid ? i_deck_card : 6'd0;
   assign o_player     = player;
   assign o_remaining  = (state_q inside {SHUF_REQ, SHUF_WAIT, DEAL, SERVE}) ? DECK - ptr_q : 7'd0;
   assign o_busy       = state_q inside {SHUF_REQ, SHUF_WAIT, DEAL};
   assign o_empty      = (state_q == EMPTY);

endmodule

// File: tb/tb_uno_deal_ctrl.sv
// Directed bench for uno_deal_ctrl: reset, shuffle/deal, round-robin
// serve, deck exhaustion (or reshuffle), restarts and mid-game reset.
module tb_uno_deal_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_new_game;
   logic       o_shuf_start;
   logic       i_shuf_done;
   logic [6:0] o_deck_addr;
   logic [5:0] i_deck_card;
   logic [3:0] i_req;
   logic [3:0] o_gnt;
   logic       o_card_valid;
   logic [5:0] o_card;
   logic [1:0] o_player;
   logic [6:0] o_remaining;
   logic       o_busy;
   logic       o_empty;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   // Deck store model: card at index a is a[5:0] ^ 6'h2A.
   assign i_deck_card = o_deck_addr[5:0] ^ 6'h2A;

   uno_deal_ctrl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_new_game(i_new_game),
      .o_shuf_start(o_shuf_start), .i_shuf_done(i_shuf_done),
      .o_deck_addr(o_deck_addr), .i_deck_card(i_deck_card), .i_req(i_req),
      .o_gnt(o_gnt), .o_card_valid(o_card_valid), .o_card(o_card),
      .o_player(o_player), .o_remaining(o_remaining), .o_busy(o_busy),
      .o_empty(o_empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_gnt"},   32'(o_gnt), 0);
      chk({tag, "_valid"}, 32'(o_card_valid), 0);
      chk({tag, "_card"},  32'(o_card), 0);
      chk({tag, "_start"}, 32'(o_shuf_start), 0);
   endtask

   task automatic shuffle_done();
      i_shuf_done = 1'b1; #2; tick();
      i_shuf_done = 1'b0;
   endtask

   task automatic deal_cards(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         #2;
         chk({tag, "_valid"},  32'(o_card_valid), 1);
         chk({tag, "_addr"},   32'(o_deck_addr), 32'(i));
         chk({tag, "_player"}, 32'(o_player), 32'(i % 4));
         chk({tag, "_card"},   32'(o_card), 32'((i & 63) ^ 42));
         chk({tag, "_gnt"},    32'(o_gnt), 0);
         if (i < n - 1) tick();
      end
   endtask

   initial begin
      i_rst_n = 1'b0; i_req = 4'hF; i_new_game = 1'b0; i_shuf_done = 1'b0;
      #2;
      chk_quiet("rst");
      chk("rst_addr", 32'(o_deck_addr), 0);
      chk("rst_player", 32'(o_player), 0);
      chk("rst_rem", 32'(o_remaining), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_empty", 32'(o_empty), 0);
      tick(); tick();
      i_rst_n = 1'b1;
      repeat (3) begin #2; chk_quiet("idle_req"); tick(); end

      // Start a game; shuffler answers 5 cycles after the start pulse.
      i_req = 4'h0; i_new_game = 1'b1; #2;
      chk("ng_idle_start", 32'(o_shuf_start), 0);
      tick(); i_new_game = 1'b0; #2;
      chk("shufreq_start", 32'(o_shuf_start), 1);
      chk("shufreq_rem", 32'(o_remaining), 108);
      chk("shufreq_busy", 32'(o_busy), 1);
      tick();
      i_req = 4'hF;
      repeat (4) begin #2; chk_quiet("shufwait"); tick(); end
      i_req = 4'h0;
      shuffle_done();
      deal_cards("deal", 28);
      tick(); #2;
      chk("serve_rem", 32'(o_remaining), 80);
      chk("serve_busy", 32'(o_busy), 0);
      chk("serve_idle_valid", 32'(o_card_valid), 0);
      tick();

      // Round-robin with all players requesting.
      i_req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         logic [3:0] eg;
         eg = 4'b0001 << (k % 4);
         #2;
         chk("rr_gnt", 32'(o_gnt), 32'(eg));
         chk("rr_addr", 32'(o_deck_addr), 32'(28 + k));
         chk("rr_player", 32'(o_player), 32'(k % 4));
         chk("rr_valid", 32'(o_card_valid), 1);
         tick();
      end
      i_req = 4'b0101; #2;
      chk("rr_skip1", 32'(o_gnt), 32'h4);
      chk("rr_skip1_player", 32'(o_player), 2);
      tick(); #2;
      chk("rr_wrap0", 32'(o_gnt), 32'h1);
      tick();
      i_req = 4'h0; #2;
      chk("noreq_valid", 32'(o_card_valid), 0);
      chk("noreq_rem", 32'(o_remaining), 73);
      tick();

      // Drain the remaining 73 cards; grants continue from player 1.
      i_req = 4'hF;
      for (int k = 0; k < 73; k++) begin
         logic [3:0] eg;
         eg = 4'b0001 << ((1 + k) % 4);
         #2;
         chk("drain_gnt", 32'(o_gnt), 32'(eg));
         chk("drain_rem", 32'(o_remaining), 32'(73 - k));
         chk("drain_addr", 32'(o_deck_addr), 32'(35 + k));
         tick();
      end
`ifdef UNO_DEAL_RESHUFFLE_EN
      #2;
      chk("reshuf_start", 32'(o_shuf_start), 1);
      chk("reshuf_rem", 32'(o_remaining), 108);
      chk("reshuf_empty", 32'(o_empty), 0);
      chk("reshuf_gnt", 32'(o_gnt), 0);
      tick();
      #2; chk("reshuf_wait_gnt", 32'(o_gnt), 0); tick();
      i_req = 4'h0;
      shuffle_done();
      i_req = 4'hF; #2;
      chk("reshuf_serve_gnt", 32'(o_gnt), 32'h4);
      chk("reshuf_serve_addr", 32'(o_deck_addr), 0);
      chk("reshuf_serve_rem", 32'(o_remaining), 108);
      chk("reshuf_serve_empty", 32'(o_empty), 0);
      tick();
`else
      #2;
      chk("empty_flag", 32'(o_empty), 1);
      chk("empty_rem", 32'(o_remaining), 0);
      chk_quiet("empty");
      tick(); #2;
      chk("empty_hold_gnt", 32'(o_gnt), 0);
      chk("empty_hold_flag", 32'(o_empty), 1);
      tick();
`endif
      i_req = 4'h0;

      // Restart, then restart again in the middle of the deal.
      i_new_game = 1'b1; #2; tick(); i_new_game = 1'b0;
      #2; chk("rs1_start", 32'(o_shuf_start), 1); tick();
      #2; tick();
      shuffle_done();
      deal_cards("part", 10);
      tick();
      i_new_game = 1'b1; #2; tick(); i_new_game = 1'b0; #2;
      chk("rs2_valid", 32'(o_card_valid), 0);
      chk("rs2_start", 32'(o_shuf_start), 1);
      chk("rs2_rem", 32'(o_remaining), 108);
      tick(); #2;
      chk_quiet("rs2_wait");
      tick();
      shuffle_done();
      deal_cards("redeal", 28);
      tick();

      // Restart beats a same-cycle request.
      i_req = 4'b0010; i_new_game = 1'b1; #2;
      chk("ngreq_gnt", 32'(o_gnt), 0);
      chk("ngreq_valid", 32'(o_card_valid), 0);
      tick(); i_new_game = 1'b0; #2;
      chk("ngreq_start", 32'(o_shuf_start), 1);
      chk("ngreq_gnt2", 32'(o_gnt), 0);
      tick(); i_req = 4'h0;
      shuffle_done();
      deal_cards("deal3", 28);
      tick();
      i_req = 4'hF; #2;
      chk("prio_reset_gnt", 32'(o_gnt), 32'h1);
      tick(); #2;
      chk("serve3_gnt", 32'(o_gnt), 32'h2);

      // Asynchronous reset mid-SERVE.
      i_rst_n = 1'b0; #1;
      chk_quiet("arst");
      chk("arst_addr", 32'(o_deck_addr), 0);
      chk("arst_rem", 32'(o_remaining), 0);
      chk("arst_player", 32'(o_player), 0);
      tick();
      i_rst_n = 1'b1; #2;
      chk_quiet("post_rst");
      chk("post_rst_busy", 32'(o_busy), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
